// File: rtl/cmd_uart_encoder_pkg.sv
// Purpose: shared command codes, serializer state type and command encoder.
// Latency: n/a (declarations and one combinational helper function).
// Backpressure: n/a.
package cmd_pkg;

  localparam logic [2:0] MOTOR_FWD      = 3'b011;
  localparam logic [2:0] MOTOR_BACK     = 3'b110;
  localparam logic [2:0] MOTOR_HALT     = 3'b000;

  localparam logic [2:0] SERVO_LEFT     = 3'b011;
  localparam logic [2:0] SERVO_RIGHT    = 3'b110;
  localparam logic [2:0] SERVO_STRAIGHT = 3'b101;
  localparam logic [2:0] SERVO_HOLD     = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_e;

  // Conflicting buttons cancel out: both motor buttons halt, both steer
  // buttons hold; centre wins over any steer request.
  function automatic logic [7:0] encode_cmd(input logic fwd, input logic back,
                                            input logic left, input logic right,
                                            input logic center);
    logic [2:0] motor;
    logic [2:0] servo;
    motor = MOTOR_HALT;
    if (fwd && !back) begin
      motor = MOTOR_FWD;
    end else if (back && !fwd) begin
      motor = MOTOR_BACK;
    end
    servo = SERVO_HOLD;
    if (center) begin
      servo = SERVO_STRAIGHT;
    end else if (left && !right) begin
      servo = SERVO_LEFT;
    end else if (right && !left) begin
      servo = SERVO_RIGHT;
    end
    return {motor, servo, 2'b00};
  endfunction

endpackage

// File: rtl/cmd_uart_encoder_if.sv
// Purpose: button inputs and UART-side status of the command encoder.
// Latency: n/a (wires only).
// Backpressure: none; buttons are level inputs, outputs are free-running.
interface cmd_uart_encoder_if;
  logic       btn_fwd;
  logic       btn_back;
  logic       btn_left;
  logic       btn_right;
  logic       btn_center;
  logic       tx_pin;
  logic       busy;
  logic       cmd_sent;
  logic [7:0] last_cmd;

  // Button source / link observer side.
  modport master (
    output btn_fwd, btn_back, btn_left, btn_right, btn_center,
    input  tx_pin, busy, cmd_sent, last_cmd
  );

  // Encoder side.
  modport slave (
    input  btn_fwd, btn_back, btn_left, btn_right, btn_center,
    output tx_pin, busy, cmd_sent, last_cmd
  );
endinterface

// File: rtl/cmd_uart_encoder_serializer.sv
// Purpose: 8N1 UART transmitter, LSB first, byte latched at start.
// Latency: start in cycle N -> start bit on tx from N+1; frame is 10*BIT_CYCLES.
// Backpressure: start ignored while busy except in the done cycle (back-to-back relaunch).
module uart_tx_serializer
  import cmd_pkg::*;
#(
  parameter int BIT_CYCLES = 108
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(BIT_CYCLES - 2);

  ser_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    data_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  // Frame sequencer; line level, busy and done are registered with the state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_START;
            cnt_q   <= '0;
            data_q  <= data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= data_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= data_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (start) begin
              // Relaunch straight out of the stop bit, no idle gap.
              state_q <= S_START;
              data_q  <= data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == CNT_DONE);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/cmd_uart_encoder.sv
// Purpose: debounce five buttons, encode the car command byte, send it over UART on change or repeat tick.
// Latency: button edge -> start bit ~2 sync + DEBOUNCE_CYCLES + 2 cycles when idle.
// Backpressure: triggers during a frame set pending; one follow-up frame with the latest cmd.
module cmd_uart_encoder
  import cmd_pkg::*;
#(
  parameter int SYS_CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE       = 921600,
  parameter int REPEAT_HZ       = 50,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  cmd_uart_encoder_if.slave  bus
);

  localparam int BIT_CYCLES    = SYS_CLK_FREQ / BAUD_RATE;
  localparam int REPEAT_CYCLES = SYS_CLK_FREQ / REPEAT_HZ;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_CYCLES - 1);

  // Bit order everywhere: {center, right, left, back, fwd}.
  logic [4:0]     btn_raw;
  logic [4:0]     sync1_q, sync2_q;
  logic [4:0]     deb_q, deb_d;
  logic [DBW-1:0] db_cnt_q [5];
  logic [DBW-1:0] db_cnt_d [5];
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     last_cmd_q, last_cmd_d;
  logic [RW-1:0]  rep_q, rep_d;
  logic           pending_q, pending_d;
  logic           change, tick, launch;
  logic           ser_busy, ser_done;

  assign btn_raw = {bus.btn_center, bus.btn_right, bus.btn_left, bus.btn_back, bus.btn_fwd};

  // Debounce: flip only after a full run of samples that disagree with the current value.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Encode, trigger and launch decisions; the repeat counter holds at its limit until a launch.
  always_comb begin
    cmd_d      = encode_cmd(deb_q[0], deb_q[1], deb_q[2], deb_q[3], deb_q[4]);
    change     = (cmd_q != last_cmd_q);
    tick       = (rep_q == REP_LAST);
    launch     = (!ser_busy || ser_done) && (change || tick || pending_q);
    pending_d  = launch ? 1'b0 : (pending_q || change || tick);
    last_cmd_d = launch ? cmd_q : last_cmd_q;
    rep_d      = launch ? '0 : (tick ? rep_q : rep_q + 1'b1);
  end

  // All input-path and trigger state, async reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      cmd_q      <= '0;
      last_cmd_q <= '0;
      rep_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      cmd_q      <= cmd_d;
      last_cmd_q <= last_cmd_d;
      rep_q      <= rep_d;
      pending_q  <= pending_d;
    end
  end

  uart_tx_serializer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_ser (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .start   (launch),
    .data    (cmd_q),
    .tx      (bus.tx_pin),
    .busy    (ser_busy),
    .done    (ser_done)
  );

  assign bus.busy     = ser_busy;
  assign bus.cmd_sent = ser_done;
  assign bus.last_cmd = last_cmd_q;

endmodule

// File: doc/cmd_uart_encoder.md
Name: cmd_uart_encoder

Overview:
Remote-controller end of the one-byte car command link: samples five push-buttons, debounces them and encodes them into the car's command byte.
- Byte layout: [7:5] motor, [4:2] servo, [1:0] = 00.
- Serialises the byte as 8N1 UART on tx_pin, immediately on any command change and periodically as keep-alive / steering-rate repeat.
- Sits in the controller-side top level; tx_pin drives the radio/serial link feeding the car's UART receiver.

Parameters:
SYS_CLK_FREQ, 100_000_000, sys_clk frequency in Hz
BAUD_RATE, 921600, UART bit rate; BIT_CYCLES = SYS_CLK_FREQ/BAUD_RATE (integer truncation, 108 at defaults)
REPEAT_HZ, 50, keep-alive rate; REPEAT_CYCLES = SYS_CLK_FREQ/REPEAT_HZ
DEBOUNCE_CYCLES, 1_000_000, stable cycles required before a debounced button changes

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_fwd  in  1  forward button, async, active-high
btn_back  in  1  backward button
btn_left  in  1  steer-left button
btn_right  in  1  steer-right button
btn_center  in  1  re-centre steering button
tx_pin  out  1  UART line, idle high
busy  out  1  high from first start-bit cycle through last stop-bit cycle
cmd_sent  out  1  one-cycle pulse on the last stop-bit cycle
last_cmd  out  8  most recently launched command byte

Behaviour:
- Reset (async, all state): tx_pin=1, busy=0, cmd_sent=0, last_cmd=8'h00, debounced buttons=0, pending=0, repeat counter=0, serializer FSM=IDLE.
- Input path:
  - Each button goes through a 2-flop synchroniser, then a per-button debounce counter.
  - The debounced value takes the synchronised value only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current debounced value.
  - The counter clears whenever the sample equals the current debounced value.
- Encoding (combinational from debounced state, then registered as cmd):
  - Motor: fwd&~back -> 011; back&~fwd -> 110; otherwise (none or both) -> 000 (halt).
  - Servo: center -> 101 (overrides left/right); left&~right -> 011; right&~left -> 110; otherwise -> 000 (hold).
  - Bits [1:0] always 00.
- Triggers:
  - change = registered cmd differs from last_cmd.
  - tick = repeat counter reaches REPEAT_CYCLES-1.
  - The repeat counter reloads to 0 on every frame launch, so a tick fires REPEAT_CYCLES cycles after the last launch.
- Launch rules:
  - Trigger (change or tick) while IDLE in cycle N: last_cmd <= cmd, frame start bit on tx_pin from cycle N+1.
  - Trigger while busy: set pending. On the cmd_sent cycle with pending=1, clear pending and launch the current cmd so its start bit begins the next cycle. No idle gap is required beyond the stop bit.
  - Simultaneous change and tick produce a single frame.
  - Multiple changes during one frame produce one follow-up frame carrying the latest cmd.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE (or -> START when relaunching).
  - Each state holds for BIT_CYCLES cycles, timed by a bit-cycle counter.
  - DATA sends bits 0..7, LSB first, with a 3-bit index.
  - Levels: START=0, STOP=1, IDLE=1.
  - Frame length is exactly 10*BIT_CYCLES cycles.
  - The data byte is latched at launch and is immune to cmd changes mid-frame.
- Reset mid-frame: tx_pin returns high asynchronously and the partial frame is abandoned. After reset, cmd=0x00 equals last_cmd, so the first frame (0x00) is sent on the first tick.
- All counters are sized by $clog2 of their limit and saturate or wrap only at the limits stated above.

Decomposition:
- Package cmd_pkg holds:
  - Motor codes: MOTOR_FWD=3'b011, MOTOR_BACK=3'b110, MOTOR_HALT=3'b000.
  - Servo codes: SERVO_LEFT=3'b011, SERVO_RIGHT=3'b110, SERVO_STRAIGHT=3'b101, SERVO_HOLD=3'b000.
  - The serializer state enum.
- One sub-module: uart_tx_serializer, with inputs start and data[7:0] and outputs tx, busy and done, parameterised by BIT_CYCLES.
- Synchroniser, debounce, encode, trigger and pending logic stay in the top block.

Test Plan:
Bench parameters for all scenarios: SYS_CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_CYCLES=10), REPEAT_HZ=1000 (REPEAT_CYCLES=1000), DEBOUNCE_CYCLES=4.
- Reset idle: no buttons -> tx_pin=1 and busy=0 until cycle ~1000 after reset; then one 0x00 frame lasting 100 cycles, cmd_sent pulses once, then a 0x00 frame every 1000 cycles.
- Press btn_fwd held -> frame 0x60 within 2+4+2 cycles of the edge; bit levels 0,0,0,0,0,0,1,1,0,1, each 10 cycles; last_cmd=0x60; repeats 1000 cycles after launch.
- Hold fwd, then add left 30 cycles into the 0x60 frame -> pending set; 0x6C start bit begins the cycle after the 0x60 cmd_sent, with no idle gap.
- btn_back+btn_right -> 0xD8. fwd+back+left+right -> 0x00 (no new frame if already 0x00). center+left+fwd -> 0x74.
- Glitch: btn_left high for 3 cycles only -> no debounced change and no frame. A 5-cycle pulse -> 0x0C frame, followed by a 0x00 frame on release.
- Assert rst_n low at cycle 45 of a frame -> tx_pin=1, busy=0 and last_cmd=0x00 immediately; after release, no frame until the tick.
